// File: rtl/rd_sched_pkg.sv
// Shared AXI read-scheduler types: FSM state enum, master-ID field position, round-robin pick.
// AXI_IDS_BITS normally comes from the AXI define file; a fallback keeps this slice self-contained.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  localparam int MID_LSB = 4;
  localparam int MID_MSB = 7;
  localparam int MID_W   = MID_MSB - MID_LSB + 1;

  // On a tie the master that did not win last time is chosen.
  function automatic logic rr_pick(input logic m0_valid, input logic m1_valid,
                                   input logic last_grant);
    logic pick;
    if (m0_valid && m1_valid) begin
      pick = ~last_grant;
    end else begin
      pick = m1_valid;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rd_sched.sv
// Two-master AXI read-address scheduler allowing a single outstanding read.
// Optional read-data watchdog enabled by defining RD_SCHED_TIMEOUT_EN.
module rd_sched
  import rd_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       M0_ARValid,
  input  logic                       M1_ARValid,
  output logic                       M0_ARReady,
  output logic                       M1_ARReady,
  output logic                       O_ARValid,
  input  logic                       O_ARReady,
  output logic                       O_Sel,
  input  logic                       R_Valid,
  input  logic                       R_Ready,
  input  logic                       R_Last,
  input  logic [`AXI_IDS_BITS-1:0]   R_ID,
  output logic                       O_Busy,
  output logic                       O_Timeout
);

  rd_state_e state_q, state_d;
  logic      sel_q, sel_d;
  logic      last_grant_q, last_grant_d;
  logic      grant;
  logic      r_done;

  assign r_done = R_Valid && R_Ready && R_Last &&
                  (R_ID[MID_MSB:MID_LSB] == MID_W'(sel_q));
  assign grant  = rr_pick(M0_ARValid, M1_ARValid, last_grant_q);

`ifdef RD_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
`ifdef RD_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (M0_ARValid || M1_ARValid) begin
          sel_d        = grant;
          last_grant_d = grant;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (O_ARReady) begin
          state_d = DATA;
`ifdef RD_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      DATA: begin
        // Completion takes priority over the watchdog in the same cycle.
        if (r_done) begin
          state_d = IDLE;
        end
`ifdef RD_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef RD_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign O_Timeout = timeout_q;
`else
  assign O_Timeout = 1'b0;
`endif

  assign O_ARValid  = (state_q == ADDR);
  assign O_Sel      = sel_q;
  assign O_Busy     = (state_q != IDLE);
  assign M0_ARReady = (state_q == ADDR) && !sel_q && O_ARReady;
  assign M1_ARReady = (state_q == ADDR) &&  sel_q && O_ARReady;

endmodule

// File: tb/tb_rd_sched.sv
// Directed self-checking bench for rd_sched; outputs are sampled on the falling clock edge.
// Define RD_SCHED_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYC=8.
module tb_rd_sched;

  logic       clk;
  logic       rst;
  logic       m0_arvalid, m1_arvalid;
  logic       m0_arready, m1_arready;
  logic       o_arvalid, o_arready, o_sel;
  logic       r_valid, r_ready, r_last;
  logic [7:0] r_id;
  logic       o_busy, o_timeout;

  int vectors;
  int miscompares;

  rd_sched #(.TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .M0_ARValid(m0_arvalid),
    .M1_ARValid(m1_arvalid),
    .M0_ARReady(m0_arready),
    .M1_ARReady(m1_arready),
    .O_ARValid (o_arvalid),
    .O_ARReady (o_arready),
    .O_Sel     (o_sel),
    .R_Valid   (r_valid),
    .R_Ready   (r_ready),
    .R_Last    (r_last),
    .R_ID      (r_id),
    .O_Busy    (o_busy),
    .O_Timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic m0, input logic m1, input logic ar_rdy);
    m0_arvalid = m0;
    m1_arvalid = m1;
    o_arready  = ar_rdy;
  endtask

  task automatic driveR(input logic v, input logic last, input logic [7:0] id);
    r_valid = v;
    r_ready = v;
    r_last  = last;
    r_id    = id;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    driveR(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic exp_sel [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset holds outputs low even with a request pending.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    driveR(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("rst_arvalid", {31'b0, o_arvalid}, 0);
    checkOutput("rst_busy", {31'b0, o_busy}, 0);
    checkOutput("rst_sel", {31'b0, o_sel}, 0);
    checkOutput("rst_m0rdy", {31'b0, m0_arready}, 0);
    checkOutput("rst_m1rdy", {31'b0, m1_arready}, 0);
    checkOutput("rst_timeout", {31'b0, o_timeout}, 0);

    // Single M0 request: AR valid one cycle later, DATA the cycle after.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1_c0_arvalid", {31'b0, o_arvalid}, 0);
    step();
    checkOutput("t1_c1_arvalid", {31'b0, o_arvalid}, 1);
    checkOutput("t1_c1_m0rdy", {31'b0, m0_arready}, 1);
    checkOutput("t1_c1_m1rdy", {31'b0, m1_arready}, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    checkOutput("t1_c2_busy", {31'b0, o_busy}, 1);
    checkOutput("t1_c2_arvalid", {31'b0, o_arvalid}, 0);
    driveR(1'b1, 1'b1, 8'h00);
    step();
    checkOutput("t1_done_busy", {31'b0, o_busy}, 0);
    driveR(1'b0, 1'b0, 8'h00);

    // Both masters requesting continuously: round-robin M0, M1, M0.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int t = 0; t < 3; t++) begin
      step();
      checkOutput("rr_arvalid", {31'b0, o_arvalid}, 1);
      checkOutput("rr_sel", {31'b0, o_sel}, {31'b0, exp_sel[t]});
      checkOutput("rr_m0rdy", {31'b0, m0_arready}, {31'b0, ~exp_sel[t]});
      checkOutput("rr_m1rdy", {31'b0, m1_arready}, {31'b0, exp_sel[t]});
      step();
      checkOutput("rr_data_busy", {31'b0, o_busy}, 1);
      checkOutput("rr_data_arvalid", {31'b0, o_arvalid}, 0);
      driveR(1'b1, 1'b1, {3'b000, exp_sel[t], 4'h0});
      step();
      checkOutput("rr_idle_busy", {31'b0, o_busy}, 0);
      checkOutput("rr_idle_arvalid", {31'b0, o_arvalid}, 0);
      driveR(1'b0, 1'b0, 8'h00);
    end

    // Decoder stalls for five cycles: request and select stay put, no ready.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_arvalid", {31'b0, o_arvalid}, 1);
      checkOutput("stall_sel", {31'b0, o_sel}, 1);
      checkOutput("stall_m0rdy", {31'b0, m0_arready}, 0);
      checkOutput("stall_m1rdy", {31'b0, m1_arready}, 0);
      step();
    end
    o_arready = 1'b1;
    #1;
    checkOutput("stall_release_m1rdy", {31'b0, m1_arready}, 1);
    step();
    checkOutput("stall_data_busy", {31'b0, o_busy}, 1);
    driveR(1'b1, 1'b1, 8'h10);
    step();
    checkOutput("stall_done_busy", {31'b0, o_busy}, 0);
    driveR(1'b0, 1'b0, 8'h00);

    // R beats for the other master or without RLAST are ignored.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    driveR(1'b1, 1'b1, 8'h10);
    step();
    checkOutput("id_wrong_busy", {31'b0, o_busy}, 1);
    driveR(1'b1, 1'b0, 8'h00);
    step();
    checkOutput("id_nolast_busy", {31'b0, o_busy}, 1);
    driveR(1'b1, 1'b1, 8'h00);
    step();
    checkOutput("id_match_busy", {31'b0, o_busy}, 0);
    driveR(1'b0, 1'b0, 8'h00);

    // Reset during DATA aborts immediately; next request granted normally.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    checkOutput("mid_pre_busy", {31'b0, o_busy}, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'b0, o_busy}, 0);
    checkOutput("mid_rst_arvalid", {31'b0, o_arvalid}, 0);
    step();
    rst = 1'b1;
    step();
    checkOutput("mid_after_m0rdy", {31'b0, m0_arready}, 0);
    checkOutput("mid_after_busy", {31'b0, o_busy}, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step();
    checkOutput("mid_regrant_arvalid", {31'b0, o_arvalid}, 1);
    checkOutput("mid_regrant_sel", {31'b0, o_sel}, 1);
    checkOutput("mid_regrant_m1rdy", {31'b0, m1_arready}, 1);
    checkOutput("mid_regrant_m0rdy", {31'b0, m0_arready}, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();

    // Read data never arrives.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    checkOutput("wd_entry_busy", {31'b0, o_busy}, 1);
`ifdef RD_SCHED_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step();
      checkOutput("wd_wait_timeout", {31'b0, o_timeout}, 0);
      checkOutput("wd_wait_busy", {31'b0, o_busy}, 1);
    end
    step();
    checkOutput("wd_fire_timeout", {31'b0, o_timeout}, 1);
    checkOutput("wd_fire_busy", {31'b0, o_busy}, 0);
    step();
    checkOutput("wd_after_timeout", {31'b0, o_timeout}, 0);
`else
    repeat (12) step();
    checkOutput("nowd_timeout", {31'b0, o_timeout}, 0);
    checkOutput("nowd_busy", {31'b0, o_busy}, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rd_sched.md
RD_SCHED -- requirements
Module: rd_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, meaning the read-data watchdog limit in cycles (used only when RD_SCHED_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port M0_ARValid  input  1  master 0 (IM) read-address request.
REQ-005 SHALL have port M1_ARValid  input  1  master 1 (DM) read-address request.
REQ-006 SHALL have port M0_ARReady  output  1  master 0 address accepted.
REQ-007 SHALL have port M1_ARReady  output  1  master 1 address accepted.
REQ-008 SHALL have port O_ARValid  output  1  shared AR valid toward the address decoder.
REQ-009 SHALL have port O_ARReady  input  1  shared AR ready from the address decoder.
REQ-010 SHALL have port O_Sel  output  1  mux select for the AR payload: 0 = M0, 1 = M1.
REQ-011 SHALL have ports R_Valid, R_Ready and R_Last  input  1 each  monitored read-data handshake.
REQ-012 SHALL have port R_ID  input  `AXI_IDS_BITS  read-data ID; bits [7:4] carry the master number.
REQ-013 SHALL have port O_Busy  output  1  a read transaction is in flight.
REQ-014 SHALL have port O_Timeout  output  1  single-cycle watchdog abort pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR and DATA.
REQ-016 In IDLE with exactly one ARValid high, SHALL latch that master into sel and move to ADDR on the next edge.
REQ-017 In IDLE with both ARValid high, SHALL grant the master that is not last_grant (round-robin).
REQ-018 On every grant, SHALL update last_grant to the granted master.
REQ-019 In IDLE with no ARValid high, SHALL stay in IDLE.
REQ-020 SHALL drive O_ARValid = (state==ADDR) and O_Sel = sel; latency from request to O_ARValid SHALL be exactly 1 cycle.
REQ-021 SHALL drive Mx_ARReady = (state==ADDR) && (sel==x) && O_ARReady, combinationally.
REQ-022 The non-selected master's ARReady SHALL be 0 in every state.
REQ-023 In ADDR, SHALL move to DATA on O_ARValid && O_ARReady; otherwise SHALL hold ADDR with sel stable.
REQ-024 In DATA, SHALL return to IDLE on R_Valid && R_Ready && R_Last && R_ID[7:4]==sel.
REQ-025 In DATA, R beats with a non-matching ID or R_Last=0 SHALL be ignored.
REQ-026 SHALL allow only one outstanding read; no new grant SHALL occur before the return to IDLE.
REQ-027 SHALL drive O_Busy = (state != IDLE).
REQ-028 When a request arrives in the same cycle as the completing RLAST, SHALL return to IDLE first and grant it the following cycle (no IDLE bypass).

Reset
REQ-029 On rst low, SHALL asynchronously set state=IDLE, sel=0, last_grant=1 (M0 wins the first tie) and watchdog counter=0.
REQ-030 During reset, SHALL hold all outputs at 0.
REQ-031 A reset mid-transaction SHALL discard it; no ARReady SHALL be issued for it afterwards.

Configuration
REQ-032 With RD_SCHED_TIMEOUT_EN defined, SHALL count cycles spent in DATA and clear the counter on entry to DATA.
REQ-033 With RD_SCHED_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC-1 without completion, SHALL pulse O_Timeout for 1 cycle and force IDLE.
REQ-034 With RD_SCHED_TIMEOUT_EN defined, if completion and timeout occur in the same cycle, completion SHALL win and O_Timeout SHALL stay 0.
REQ-035 Without RD_SCHED_TIMEOUT_EN, SHALL omit the counter, tie O_Timeout to 0 and leave DATA only on completion.

Structure
REQ-036 SHALL place the state enum (IDLE/ADDR/DATA) and the master-ID field position constants in the shared AXI package; width macros SHALL come from the existing AXI define file.
REQ-037 SHALL be one flat module; the round-robin pick SHALL be a function, not a sub-module.

Verification
REQ-038 Test: reset, M0_ARValid=1, O_ARReady=1 -> O_ARValid=1 at cycle 1; M0_ARReady=1 at cycle 1; DATA at cycle 2.
REQ-039 Test: both valid from reset -> grants in the order M0, M1, M0 across three transactions (each ended by RLAST with the matching ID).
REQ-040 Test: O_ARReady held 0 for 5 cycles -> O_ARValid=1 and O_Sel stable throughout; no ARReady pulse.
REQ-041 Test: in DATA, RLAST with ID[7:4]=1 while sel=0 -> stays in DATA; then ID[7:4]=0 -> IDLE on the next cycle.
REQ-042 Test: rst low during DATA -> O_Busy=0 immediately; the next request is granted normally.
REQ-043 Test: with RD_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, no R beats -> O_Timeout pulses 1 cycle, 8 cycles after DATA entry; state returns to IDLE.
